// File: rtl/fetch.sv
// fetch: instruction fetch stage with a single outstanding memory request.
// Issues one request at a time and hands each returned word to the decode
// register. A one-entry buffer parks a response that arrives while decode is
// stalled. A redirect (haz_bubble) overrides every other event, and a response
// that is still in flight when a redirect occurs is marked stale and dropped.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   haz_stall, haz_bubble        decode stall / redirect from hazard unit
//   jmp_tgt                      redirect target (low two bits ignored)
//   imem_req_vld/rdy/addr        fetch request handshake
//   imem_rsp_vld/data            fetch response
//   dec_vld/pc/pc4/instr         decode-facing register
module fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        haz_stall,
  input  logic        haz_bubble,
  input  logic [31:0] jmp_tgt,
  output logic        imem_req_vld,
  input  logic        imem_req_rdy,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_vld,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc4,
  output logic [31:0] dec_instr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  localparam slot_t SLOT_RST = '{vld: 1'b0, pc: 32'h0, instr: 32'h0};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  slot_t       buf_q, buf_d;
  slot_t       dec_q, dec_d;

  logic        req_fire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC & 32'hFFFF_FFFC;
      req_pc_q <= 32'h0;
      kill_q   <= 1'b0;
      buf_q    <= SLOT_RST;
      dec_q    <= SLOT_RST;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      buf_q    <= buf_d;
      dec_q    <= dec_d;
    end
  end

  // Output logic: requests only go out from REQ, and never in a redirect
  // cycle since pc_q is about to be replaced.
  always_comb begin
    imem_req_vld  = (state_q == S_REQ) & ~haz_bubble;
    imem_req_addr = pc_q;
  end

  assign req_fire  = imem_req_vld & imem_req_rdy;
  assign dec_vld   = dec_q.vld;
  assign dec_pc    = dec_q.pc;
  assign dec_pc4   = dec_q.pc + 32'd4;
  assign dec_instr = dec_q.instr;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    buf_d    = buf_q;
    dec_d    = dec_q;

    // Decode register holds under stall; otherwise it drains to a bubble
    // unless something below loads it this cycle.
    if (!haz_stall) dec_d.vld = 1'b0;

    if (haz_bubble) begin
      pc_d      = jmp_tgt & 32'hFFFF_FFFC;
      dec_d.vld = 1'b0;
      buf_d.vld = 1'b0;
      case (state_q)
        S_WAIT: begin
          if (imem_rsp_vld) begin
            // Response lands in the redirect cycle: drop it right here.
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            // Response still in flight: drop it when it shows up.
            kill_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_vld) begin
            state_d = S_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else if (!haz_stall) begin
              dec_d = '{vld: 1'b1, pc: req_pc_q, instr: imem_rsp_data};
            end else begin
              buf_d   = '{vld: 1'b1, pc: req_pc_q, instr: imem_rsp_data};
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!haz_stall) begin
            dec_d     = buf_q;
            buf_d.vld = 1'b0;
            state_d   = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for fetch. A memory model answers each accepted
// request after a programmable latency with a word derived from its address.
// Stimulus pushes the expected request addresses and decode loads into
// queues; independent monitors pop and compare as the DUT produces them.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        haz_stall;
  logic        haz_bubble;
  logic [31:0] jmp_tgt;
  logic        imem_req_vld;
  logic        imem_req_rdy;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_vld;
  logic [31:0] imem_rsp_data;
  logic        dec_vld;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc4;
  logic [31:0] dec_instr;

  fetch #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .haz_stall    (haz_stall),
    .haz_bubble   (haz_bubble),
    .jmp_tgt      (jmp_tgt),
    .imem_req_vld (imem_req_vld),
    .imem_req_rdy (imem_req_rdy),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_vld (imem_rsp_vld),
    .imem_rsp_data(imem_rsp_data),
    .dec_vld      (dec_vld),
    .dec_pc       (dec_pc),
    .dec_pc4      (dec_pc4),
    .dec_instr    (dec_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } dec_exp_t;

  logic [31:0] req_q[$];
  dec_exp_t    dec_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          hs_cnt  = 0;
  int          dec_cnt = 0;
  int          lat     = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic push_dec(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] instr);
    dec_exp_t e;
    e.pc = pc; e.pc4 = pc4; e.instr = instr;
    dec_q.push_back(e);
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_cnt < target && k < 40) begin @(negedge clk); k++; end
    chk("wait_hs_timeout", 32'(hs_cnt), 32'(target));
  endtask

  task automatic wait_dec(input int target);
    int k = 0;
    while (dec_cnt < target && k < 40) begin @(negedge clk); k++; end
    chk("wait_dec_timeout", 32'(dec_cnt), 32'(target));
  endtask

  // Memory model: samples the handshake just before the edge, answers
  // 'lat' cycles after acceptance. Data = 0x24080001 ^ (addr[15:0] << 16).
  initial begin
    bit          acc;
    bit          pend;
    int          cnt;
    logic [31:0] acc_addr;
    logic [31:0] paddr;
    pend = 0; cnt = 0; paddr = '0;
    imem_rsp_vld = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(negedge clk); #4;
      acc = imem_req_vld && imem_req_rdy && !rst;
      acc_addr = imem_req_addr;
      @(posedge clk); #1;
      imem_rsp_vld = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (acc) begin pend = 1; cnt = lat; paddr = acc_addr; end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            imem_rsp_vld  = 1'b1;
            imem_rsp_data = 32'h2408_0001 ^ {paddr[15:0], 16'h0};
            pend = 0;
          end
        end
      end
    end
  end

  // Request monitor
  initial begin
    forever begin
      @(negedge clk); #4;
      if (!rst && imem_req_vld && imem_req_rdy) begin
        hs_cnt++;
        if (req_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL req_unexp: got addr %08h expected no request", imem_req_addr);
        end else begin
          chk("req_addr", imem_req_addr, req_q.pop_front());
        end
      end
    end
  end

  // Decode monitor: a load can only happen on an edge with no stall/bubble.
  initial begin
    bit       free;
    dec_exp_t e;
    forever begin
      @(negedge clk); #4;
      free = !rst && !haz_stall && !haz_bubble;
      @(posedge clk); #2;
      if (free && dec_vld) begin
        dec_cnt++;
        if (dec_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dec_unexp: got pc %08h expected no decode load", dec_pc);
        end else begin
          e = dec_q.pop_front();
          chk("dec_pc", dec_pc, e.pc);
          chk("dec_pc4", dec_pc4, e.pc4);
          chk("dec_instr", dec_instr, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; haz_stall = 1'b0; haz_bubble = 1'b0; jmp_tgt = '0; imem_req_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dec_vld",   32'(dec_vld), 32'd0);
    chk("rst_dec_pc",    dec_pc,       32'h0);
    chk("rst_dec_pc4",   dec_pc4,      32'h4);
    chk("rst_dec_instr", dec_instr,    32'h0);
    chk("rst_addr",      imem_req_addr, 32'hBFC0_0000);

    // Reset release and two back-to-back fetches, latency 1
    @(negedge clk);
    req_q.push_back(32'hBFC0_0000);
    req_q.push_back(32'hBFC0_0004);
    push_dec(32'hBFC0_0000, 32'hBFC0_0004, 32'h2408_0001);
    push_dec(32'hBFC0_0004, 32'hBFC0_0008, 32'h240C_0001);
    rst = 1'b0; imem_req_rdy = 1'b1;
    #1;
    chk("t1_first_vld", 32'(imem_req_vld), 32'd1);
    wait_hs(2);
    imem_req_rdy = 1'b0;
    wait_dec(2);

    // Stall holds decode, response parked in HOLD, no request meanwhile
    imem_req_rdy = 1'b1;
    req_q.push_back(32'hBFC0_0008);
    req_q.push_back(32'hBFC0_000C);
    push_dec(32'hBFC0_0008, 32'hBFC0_000C, 32'h2400_0001);
    push_dec(32'hBFC0_000C, 32'hBFC0_0010, 32'h2404_0001);
    wait_dec(3);
    haz_stall = 1'b1;
    #1;
    chk("t2_pre_vld", 32'(dec_vld), 32'd1);
    chk("t2_pre_pc",  dec_pc, 32'hBFC0_0008);
    @(negedge clk);
    imem_req_rdy = 1'b0;
    #1;
    chk("t2_hold_pc",    dec_pc,    32'hBFC0_0008);
    chk("t2_hold_instr", dec_instr, 32'h2400_0001);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      imem_req_rdy = 1'b1;
      #1;
      chk("t2_hold_noreq", 32'(imem_req_vld), 32'd0);
      chk("t2_hold_vld",   32'(dec_vld),      32'd1);
      chk("t2_hold_pc2",   dec_pc,            32'hBFC0_0008);
    end
    @(negedge clk);
    haz_stall = 1'b0;
    #1;
    chk("t2_release_noreq", 32'(imem_req_vld), 32'd0);
    @(negedge clk);
    imem_req_rdy = 1'b0;
    #1;
    chk("t2_after_vld",   32'(dec_vld), 32'd1);
    chk("t2_after_pc",    dec_pc,       32'hBFC0_000C);
    chk("t2_after_instr", dec_instr,    32'h2404_0001);
    wait_dec(4);

    // Redirect while waiting, stale response arrives next cycle
    @(negedge clk);
    lat = 2; imem_req_rdy = 1'b1;
    req_q.push_back(32'hBFC0_0010);
    req_q.push_back(32'h0040_0010);
    push_dec(32'h0040_0010, 32'h0040_0014, 32'h2418_0001);
    wait_hs(5);
    haz_bubble = 1'b1; jmp_tgt = 32'h0040_0013;
    #1;
    chk("t3_bubble_noreq", 32'(imem_req_vld), 32'd0);
    @(negedge clk);
    haz_bubble = 1'b0;
    #1;
    chk("t3_dec_clr",     32'(dec_vld),      32'd0);
    chk("t3_wait_noreq",  32'(imem_req_vld), 32'd0);
    @(negedge clk);
    #1;
    chk("t3_stale_drop",  32'(dec_vld),      32'd0);
    chk("t3_redir_vld",   32'(imem_req_vld), 32'd1);
    chk("t3_redir_addr",  imem_req_addr,     32'h0040_0010);
    wait_hs(6);
    imem_req_rdy = 1'b0;
    wait_dec(5);

    // Redirect in the same cycle as a response; target wraps at 2^32
    lat = 1; imem_req_rdy = 1'b1;
    req_q.push_back(32'h0040_0014);
    req_q.push_back(32'hFFFF_FFFC);
    req_q.push_back(32'h0000_0000);
    push_dec(32'hFFFF_FFFC, 32'h0000_0000, 32'hDBF4_0001);
    push_dec(32'h0000_0000, 32'h0000_0004, 32'h2408_0001);
    wait_hs(7);
    haz_bubble = 1'b1; jmp_tgt = 32'hFFFF_FFFF;
    @(negedge clk);
    haz_bubble = 1'b0;
    #1;
    chk("t4_drop_vld",  32'(dec_vld),      32'd0);
    chk("t4_redir_vld", 32'(imem_req_vld), 32'd1);
    chk("t4_redir_addr", imem_req_addr,    32'hFFFF_FFFC);
    wait_hs(9);
    imem_req_rdy = 1'b0;
    wait_dec(7);

    // Reset while waiting with a killed response pending
    lat = 3; imem_req_rdy = 1'b1;
    req_q.push_back(32'h0000_0004);
    wait_hs(10);
    haz_bubble = 1'b1; jmp_tgt = 32'h1234_5678;
    @(negedge clk);
    haz_bubble = 1'b0; rst = 1'b1; imem_req_rdy = 1'b0;
    #1;
    chk("t5_rst_vld",   32'(dec_vld), 32'd0);
    chk("t5_rst_pc",    dec_pc,       32'h0);
    chk("t5_rst_pc4",   dec_pc4,      32'h4);
    chk("t5_rst_instr", dec_instr,    32'h0);
    chk("t5_rst_addr",  imem_req_addr, 32'hBFC0_0000);
    @(negedge clk);
    req_q.push_back(32'hBFC0_0000);
    push_dec(32'hBFC0_0000, 32'hBFC0_0004, 32'h2408_0001);
    rst = 1'b0; imem_req_rdy = 1'b1;
    #1;
    chk("t5_first_vld",  32'(imem_req_vld), 32'd1);
    chk("t5_first_addr", imem_req_addr,     32'hBFC0_0000);
    wait_hs(11);
    imem_req_rdy = 1'b0;
    wait_dec(8);

    repeat (3) @(negedge clk);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("dec_q_empty", 32'(dec_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
